// File: rtl/cnt_ctrl.sv
// Sequencer for an external up-counter: loads a start value, enables counting
// until the counter reaches a programmable terminal value, supports pause/resume and abort.
//
// state | meaning
// IDLE  | waiting for a command, counter untouched
// LOAD  | one cycle driving load with start_reg
// RUN   | counter enabled until cnt_out reaches term_reg
// PAUSE | counting suspended by HOLD, terminal check inactive
// DONE  | terminal reached, waiting for START or ABORT
module cnt_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_out,
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] OP_SET_TERM = 2'd0;
  localparam logic [1:0] OP_START    = 2'd1;
  localparam logic [1:0] OP_HOLD     = 2'd2;
  localparam logic [1:0] OP_ABORT    = 2'd3;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] w_term_nxt;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] w_start_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_acc;
  logic             w_at_term;

  assign cmd_ready = (r_state != S_LOAD);
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_at_term = (cnt_out == r_term);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_term  <= '1;
      r_start <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_term  <= w_term_nxt;
      r_start <= w_start_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_term_nxt  = r_term;
    w_start_nxt = r_start;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_acc) begin
          case (cmd_op)
            OP_SET_TERM: w_term_nxt = cmd_data;
            OP_START: begin
              w_start_nxt = cmd_data;
              w_state_nxt = S_LOAD;
            end
            OP_HOLD:  w_err_nxt   = 1'b1;
            default:  w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_acc && cmd_op == OP_ABORT) begin
          w_state_nxt = S_IDLE;
        end else if (w_at_term) begin
          // terminal wins: any other command taken on this edge is flagged as lost
          w_state_nxt = S_DONE;
          w_err_nxt   = w_acc;
        end else if (w_acc) begin
          if (cmd_op == OP_HOLD) w_state_nxt = S_PAUSE;
          else                   w_err_nxt   = 1'b1;
        end
      end
      S_PAUSE: begin
        if (w_acc) begin
          case (cmd_op)
            OP_HOLD:  w_state_nxt = S_RUN;
            OP_ABORT: w_state_nxt = S_IDLE;
            default:  w_err_nxt   = 1'b1;
          endcase
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign load   = (r_state == S_LOAD);
  assign enab   = (r_state == S_RUN) && !w_at_term;
  assign cnt_in = r_start;
  assign busy   = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done   = (r_state == S_DONE);
  assign err    = r_err;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Bench for cnt_ctrl: attaches a loadable up-counter and checks sequencing
// against span/latency figures computed from the terminal and start values.
module tb_cnt_ctrl;

  localparam int W = 5;
  localparam logic [1:0] OP_SET = 2'd0, OP_START = 2'd1, OP_HOLD = 2'd2, OP_ABORT = 2'd3;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic [W-1:0] cnt_model = '0;
  logic         load, enab, busy, done, err;
  logic [W-1:0] cnt_in;

  int n_chk  = 0;
  int n_fail = 0;

  cnt_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_out(cnt_model),
    .load(load), .enab(enab), .cnt_in(cnt_in), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // downstream counter
  always @(posedge clk) begin
    if (load)      cnt_model <= cnt_in;
    else if (enab) cnt_model <= cnt_model + 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    int k;
    k = 0;
    while (cnt_model != v && k < 100) begin
      tick();
      k++;
    end
    chk("wait_cnt_reached", 32'(cnt_model), 32'(v));
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  // START with term already programmed; checks latency, enab/load cycles and count sequence
  task automatic run_count(input string tag, input logic [W-1:0] start, input logic [W-1:0] term);
    int n, done_edge, enab_cyc, load_cyc, err_cyc;
    logic [W-1:0] seq[$];
    n = int'((term - start) & 5'h1f);
    done_edge = -1;
    enab_cyc = 0; load_cyc = 0; err_cyc = 0;
    send(OP_START, start);
    chk({tag, "_cnt_in"}, 32'(cnt_in), 32'(start));
    chk({tag, "_ready_in_load"}, 32'(cmd_ready), 32'd0);
    if (load) load_cyc++;
    if (enab) enab_cyc++;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (err) err_cyc++;
      if (load) load_cyc++;
      if (done) begin
        done_edge = k;
        break;
      end
      if (enab) enab_cyc++;
      if (busy) seq.push_back(cnt_model);
    end
    chk({tag, "_done_edge"}, 32'(done_edge), 32'(n + 2));
    chk({tag, "_enab_cycles"}, 32'(enab_cyc), 32'(n));
    chk({tag, "_load_cycles"}, 32'(load_cyc), 32'd1);
    chk({tag, "_err_cycles"}, 32'(err_cyc), 32'd0);
    chk({tag, "_final_cnt"}, 32'(cnt_model), 32'(term));
    chk({tag, "_seq_len"}, 32'(seq.size()), 32'(n + 1));
    for (int i = 0; i < seq.size() && i <= n; i++)
      chk({tag, "_seq"}, 32'(seq[i]), 32'((start + i) & 5'h1f));
  endtask

  initial begin
    logic [W-1:0] rt, rs;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    tick(); tick();
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_enab", 32'(enab), 32'd0);
    chk("rst_cnt_in", 32'(cnt_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    tick();

    send(OP_SET, 5'd5);
    chk("set_err", 32'(err), 32'd0);
    chk("set_busy", 32'(busy), 32'd0);
    run_count("t5s2", 5'd2, 5'd5);

    send(OP_SET, 5'd1);
    run_count("wrap", 5'd30, 5'd1);

    send(OP_SET, 5'd7);
    run_count("zero", 5'd7, 5'd7);

    for (int i = 0; i < 6; i++) begin
      rt = 5'($urandom_range(0, 31));
      rs = 5'($urandom_range(0, 31));
      send(OP_SET, rt);
      run_count("rand", rs, rt);
    end

    // HOLD in IDLE is illegal
    send(OP_ABORT, 5'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    send(OP_HOLD, 5'd0);
    chk("hold_idle_err", 32'(err), 32'd1);
    chk("hold_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("hold_idle_err_clr", 32'(err), 32'd0);

    // START during RUN is illegal and leaves the run intact
    send(OP_SET, 5'd20);
    send(OP_START, 5'd0);
    wait_cnt(5'd3);
    send(OP_START, 5'd9);
    chk("start_run_err", 32'(err), 32'd1);
    chk("start_run_busy", 32'(busy), 32'd1);
    chk("start_run_cnt_in", 32'(cnt_in), 32'd0);
    tick();
    chk("start_run_err_clr", 32'(err), 32'd0);
    wait_done("start_run_done");
    chk("start_run_final", 32'(cnt_model), 32'd20);

    // pause at count 3
    send(OP_SET, 5'd10);
    send(OP_START, 5'd0);
    wait_cnt(5'd2);
    send(OP_HOLD, 5'd0);
    chk("pause_cnt", 32'(cnt_model), 32'd3);
    chk("pause_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("pause_enab", 32'(enab), 32'd0);
      chk("pause_hold_cnt", 32'(cnt_model), 32'd3);
      chk("pause_busy", 32'(busy), 32'd1);
      tick();
    end
    send(OP_HOLD, 5'd0);
    chk("resume_enab", 32'(enab), 32'd1);
    chk("resume_cnt", 32'(cnt_model), 32'd3);
    wait_done("resume_done");
    chk("resume_final", 32'(cnt_model), 32'd10);

    // reset mid-run at count 4
    send(OP_START, 5'd0);
    wait_cnt(5'd4);
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_enab", 32'(enab), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_idle_done", 32'(done), 32'd0);
    run_count("after_rst", 5'd0, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
